// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset vector, FSM encoding,
// skid payload layout and word alignment.
package fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_word_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage_skid.sv
// One-entry skid buffer holding a fetched {instr, pc} while decode is stalled.
module fetch_stage_skid
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  fetch_word_t din,
  output logic        valid,
  output fetch_word_t dout
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the payload is only meaningful when valid is set, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, runs the imem
// request/ack handshake, absorbs decode stalls and applies EX redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcplus4
);

  fetch_state_t state;
  logic         live;
  logic [31:0]  pc;
  logic [31:0]  req_addr;
  logic         acked;
  logic         skid_valid;
  logic         skid_load;
  logic         skid_unload;
  fetch_word_t  skid_din;
  fetch_word_t  skid_dout;
  logic [31:0]  add_a;
  logic [31:0]  add_sum;

  // live holds the request off until the first edge after reset release.
  assign imem_req  = live & ((state == DRAIN) | ~skid_valid);
  assign imem_addr = (state == DRAIN) ? req_addr : pc;
  assign acked     = imem_req & imem_ack;

  // One adder serves both paths: pc only advances while the skid is empty.
  assign add_a   = skid_valid ? skid_dout.pc : pc;
  assign add_sum = add_a + 32'd4;

  assign skid_din    = '{instr: imem_rdata, pc: pc};
  assign skid_load   = (state == RUN) & acked & ~redir_valid & (stall | flush);
  assign skid_unload = (state == RUN) & skid_valid & ~redir_valid & ~flush & ~stall;

  fetch_stage_skid u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (redir_valid),
    .din    (skid_din),
    .valid  (skid_valid),
    .dout   (skid_dout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      live       <= 1'b0;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      id_valid   <= 1'b0;
      id_instr   <= 32'd0;
      id_pc      <= 32'd0;
      id_pcplus4 <= 32'd0;
    end else begin
      live <= 1'b1;
      if (state == RUN) begin
        req_addr <= pc;
      end
      unique case (state)
        RUN: begin
          if (redir_valid) begin
            pc       <= word_align(redir_target);
            id_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
              state <= DRAIN;
            end
          end else begin
            if (acked) begin
              pc <= add_sum;
            end
            if (flush) begin
              id_valid <= 1'b0;
            end else if (!stall) begin
              if (acked) begin
                id_valid   <= 1'b1;
                id_instr   <= imem_rdata;
                id_pc      <= pc;
                id_pcplus4 <= add_sum;
              end else if (skid_valid) begin
                id_valid   <= 1'b1;
                id_instr   <= skid_dout.instr;
                id_pc      <= skid_dout.pc;
                id_pcplus4 <= add_sum;
              end else begin
                id_valid <= 1'b0;
              end
            end
          end
        end
        DRAIN: begin
          // The outstanding wrong-path word is absorbed here and never reaches IF/ID.
          id_valid <= 1'b0;
          if (redir_valid) begin
            pc <= word_align(redir_target);
          end
          if (imem_ack) begin
            state <= RUN;
          end
        end
      endcase
    end
  end

endmodule
